// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store sequencing controller: RV32I func3 codes
// and the sequencing FSM state encoding.
package lsu_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W     = 32;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_B_UN = 3'b100;
  localparam logic [2:0] F3_H_UN = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ0 = 3'd1,
    ST_RSP0 = 3'd2,
    ST_REQ1 = 3'd3,
    ST_RSP1 = 3'd4,
    ST_DONE = 3'd5
  } lsu_state_e;

  // Byte mask of an access of the given size class, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size_sel);
    logic [7:0] m;
    m = 8'h0F;
    if (size_sel == F3_BYTE[1:0]) m = 8'h01;
    else if (size_sel == F3_HALF[1:0]) m = 8'h03;
    return m;
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Lane alignment for one access: byte-enable mask across two words, the split
// flag, store data shifted into lanes and load data shifted back down.
module lsu_ctrl_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]          size_sel,
  input  logic [1:0]          off,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [2*DATA_W-1:0] rdata,
  output logic [7:0]          mask8,
  output logic                split,
  output logic [2*DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0]   ldata
);

  logic [4:0] sh;

  always_comb begin
    sh       = {off, 3'b000};
    mask8    = size_mask(size_sel) << off;
    split    = |mask8[7:4];
    wdata_sh = {DATA_W'(0), wdata} << sh;
    ldata    = DATA_W'(rdata >> sh);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: drives a req/gnt/rvalid word memory port,
// splitting word-crossing accesses into two beats and stalling until done.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_func3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic [2:0]        ld_func3,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata
);

  localparam int unsigned WA_W = ADDR_W - 2;

  lsu_state_e state, state_d;

  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata0, rdata1;

  logic              eff_we;
  logic [2:0]        eff_f3;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_wdata;
  logic [31:0]       rd0_n, rd1_n;
  logic [WA_W-1:0]   word_a;

  logic [7:0]        mask8;
  logic              split;
  logic [63:0]       wdata_sh;
  logic [31:0]       ldata_asm;

  assign stall = mem_req & (state != ST_DONE);

  // In IDLE the beat-0 outputs are registered straight from the request being latched.
  always_comb begin
    eff_we    = lat_we;
    eff_f3    = lat_f3;
    eff_addr  = lat_addr;
    eff_wdata = lat_wdata;
    if (state == ST_IDLE) begin
      eff_we    = mem_we;
      eff_f3    = mem_func3;
      eff_addr  = mem_addr;
      eff_wdata = mem_wdata;
    end
    word_a = eff_addr[ADDR_W-1:2];
    rd0_n  = (state == ST_RSP0 && dm_rvalid) ? dm_rdata : rdata0;
    rd1_n  = (state == ST_RSP1 && dm_rvalid) ? dm_rdata : rdata1;
  end

  lsu_ctrl_align u_align (
    .size_sel (eff_f3[1:0]),
    .off      (eff_addr[1:0]),
    .wdata    (eff_wdata),
    .rdata    ({rd1_n, rd0_n}),
    .mask8    (mask8),
    .split    (split),
    .wdata_sh (wdata_sh),
    .ldata    (ldata_asm)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (mem_req) state_d = ST_REQ0;
      ST_REQ0: if (dm_gnt) state_d = !eff_we ? ST_RSP0 : (split ? ST_REQ1 : ST_DONE);
      ST_RSP0: if (dm_rvalid) state_d = split ? ST_REQ1 : ST_DONE;
      ST_REQ1: if (dm_gnt) state_d = eff_we ? ST_DONE : ST_RSP1;
      ST_RSP1: if (dm_rvalid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch, read capture and registered port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_be     <= '0;
      dm_wdata  <= '0;
      ld_valid  <= 1'b0;
      ld_data   <= '0;
      ld_func3  <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && mem_req) begin
        lat_we    <= mem_we;
        lat_f3    <= mem_func3;
        lat_addr  <= mem_addr;
        lat_wdata <= mem_wdata;
        rdata0    <= '0;
        rdata1    <= '0;
      end else begin
        rdata0 <= rd0_n;
        rdata1 <= rd1_n;
      end

      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
      case (state_d)
        ST_REQ0: begin
          dm_req   <= 1'b1;
          dm_we    <= eff_we;
          dm_addr  <= word_a;
          dm_be    <= mask8[3:0];
          dm_wdata <= wdata_sh[31:0];
        end
        ST_REQ1: begin
          dm_req   <= 1'b1;
          dm_we    <= eff_we;
          dm_addr  <= word_a + WA_W'(1);
          dm_be    <= mask8[7:4];
          dm_wdata <= wdata_sh[63:32];
        end
        default: ;
      endcase

      ld_valid <= (state_d == ST_DONE) && !eff_we;
      if (state_d == ST_DONE && !eff_we) begin
        ld_data  <= ldata_asm;
        ld_func3 <= eff_f3;
      end
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the MEM stage and the word-organised data memory. Accepts one RV32I load or store per pipeline request and drives a req/gnt/rvalid memory port. Splits word-crossing (misaligned) accesses into two word beats and produces byte enables and shifted store data. Returns load data right-aligned with its func3 to the downstream load sign/zero-extension filter, stalling the pipeline until the access completes.

## Interface
- ADDR_W, 32, byte address width; memory word address is ADDR_W-2 bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  in  1  MEM stage has a load/store; held with operands stable while stall=1
- mem_we  in  1  1=store, 0=load
- mem_func3  in  3  RV32I func3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- mem_addr  in  ADDR_W  byte address
- mem_wdata  in  32  store data, right-aligned
- stall  out  1  freeze pipeline; = mem_req & (state != DONE)
- ld_valid  out  1  one-cycle pulse, load result valid (DONE state, load only)
- ld_data  out  32  loaded bytes right-aligned, upper bytes unfiltered
- ld_func3  out  3  latched func3 for the load filter
- dm_req  out  1  memory request, held until dm_gnt
- dm_we  out  1  write strobe
- dm_addr  out  ADDR_W-2  word address
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-aligned write data
- dm_gnt  in  1  request accepted this cycle
- dm_rvalid  in  1  read data valid, ≥1 cycle after gnt
- dm_rdata  in  32  read word

## Operation
- Size from func3[1:0]: 00→1 byte, 01→2, 10/11→4. off = addr[1:0].
- mask8 = ((1<<size)-1) << off (8 bits); split = |mask8[7:4].
- Beat0: word A = addr[ADDR_W-1:2], be = mask8[3:0], wdata = (wdata<<8*off)[31:0].
- Beat1 (split only): word A+1 modulo 2^(ADDR_W-2), be = mask8[7:4], wdata = (wdata<<8*off)[63:32].
- Load assemble: ld_data = ({rdata1, rdata0} >> 8*off)[31:0]; rdata1 = 0 when not split.
- Request fields latched in IDLE when mem_req=1.
- FSM: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
  - IDLE: mem_req → REQ0.
  - REQ0: dm_req=1 beat0. gnt: store & !split → DONE; store & split → REQ1; load → RSP0.
  - RSP0: wait rvalid, capture rdata0; then split → REQ1, else DONE.
  - REQ1: dm_req=1 beat1. gnt: store → DONE; load → RSP1.
  - RSP1: wait rvalid, capture rdata1 → DONE.
  - DONE: stall=0; ld_valid=1 if load; → IDLE unconditionally.
- Stores complete at gnt; no rvalid expected. dm_rvalid in any state other than RSP0/RSP1 is ignored.
- dm_addr/dm_be/dm_wdata/dm_we are stable and dm_req is high for every cycle in REQ0/REQ1. All are 0 outside those states.

## Timing
- Registered FSM outputs. dm_req rises the cycle after mem_req is first sampled.
- Aligned load, gnt in first req cycle, rvalid one cycle later: stall high 3 cycles, ld_valid in the 4th.
- Aligned store, immediate gnt: stall high 2 cycles.
- Split access adds REQ1 (+RSP1 for loads).
- A new request is sampled no earlier than the cycle after DONE.
- Reset: state=IDLE, dm_req=dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, ld_valid=0, ld_data=0, ld_func3=0, stall=mem_req.
- rst mid-access abandons the transaction. Outputs are at reset value in the next cycle, and a late rvalid is dropped.

## Structure
- Shared include file holds the func3 constants (BYTE, HALF, WORD, B_UN, H_UN) and the FSM state encodings.
- One combinational sub-module, lsu_align: size/off → mask8, split, shifted 64-bit store data, and load assembly shift.

## Test plan
- LW addr 0x100, gnt immediate, rvalid+1 with 0xDEADBEEF → dm_addr 0x40, be 1111, ld_valid with ld_data 0xDEADBEEF, ld_func3 010, stall 3 cycles.
- SB addr 0x203, wdata 0x000000A5 → single beat, dm_addr 0x80, be 1000, dm_wdata 0xA5000000, no ld_valid.
- LH addr 0x103, rdata0 0x11223344, rdata1 0x55667788 → beats 0x40 be 1000 and 0x41 be 0001, ld_data[15:0]=0x8811.
- SW addr 0x0FE, wdata 0xCAFEF00D → beat0 0x3F be 1100 wdata 0xF00D0000, beat1 0x40 be 0011 wdata 0x0000CAFE.
- dm_gnt held low 5 cycles in REQ0 → dm_req and fields stable throughout, stall high, state advances only on gnt.
- rst asserted in RSP0, rvalid the next cycle → IDLE, no ld_valid, dm_req=0; word-address wrap: LW addr 0xFFFFFFFE splits to words 0x3FFFFFFF then 0x00000000.
